// File: rtl/coloring_pkg.sv
// Shared types, constants and the coloring reject rule used by the arbiter.
package coloring_pkg;

  localparam int unsigned COLOR_W = 2;
  localparam int unsigned CNT_W   = 2;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  localparam color_t COLOR_0   = 2'd0;
  localparam color_t COLOR_1   = 2'd1;
  localparam color_t COLOR_2   = 2'd2;
  localparam color_t COLOR_3   = 2'd3;
  localparam cnt_t   HIST_FULL = 2'd2;

  // Third identical color in a row, or colors 0 and 1 adjacent.
  function automatic logic color_reject(input color_t last1, input color_t last2,
                                        input cnt_t cnt, input color_t c);
    logic r1;
    logic r2;
    r1 = (cnt == HIST_FULL) && (last2 == last1) && (last1 == c);
    r2 = (cnt != '0) &&
         (((last1 == COLOR_0) && (c == COLOR_1)) || ((last1 == COLOR_1) && (c == COLOR_0)));
    return r1 || r2;
  endfunction

endpackage

// File: rtl/coloring_arbiter_if.sv
// Requester/verdict bundle between color producers and the shared checker.
interface coloring_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]   req_valid;
  logic [2*N_REQ-1:0] req_color;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   clr;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic               resp_ok;
  logic [N_REQ-1:0]   check;

  modport master (
    output req_valid, req_color, clr,
    input  req_ready, resp_valid, resp_id, resp_ok, check
  );

  modport slave (
    input  req_valid, req_color, clr,
    output req_ready, resp_valid, resp_id, resp_ok, check
  );
endinterface

// File: rtl/coloring_hist.sv
// Accepted-color history and sticky violation flag for one requester.
module coloring_hist
  import coloring_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr_i,
  input  logic   upd_i,
  input  logic   ok_i,
  input  color_t color_i,
  output color_t last1_o,
  output color_t last2_o,
  output cnt_t   cnt_o,
  output logic   check_o
);

  color_t last1_q, last1_d;
  color_t last2_q, last2_d;
  cnt_t   cnt_q,   cnt_d;
  logic   check_q, check_d;

  always_comb begin
    last1_d = last1_q;
    last2_d = last2_q;
    cnt_d   = cnt_q;
    check_d = check_q;
    if (clr_i) begin
      last1_d = '0;
      last2_d = '0;
      cnt_d   = '0;
      check_d = 1'b0;
    end else if (upd_i) begin
      if (ok_i) begin
        last2_d = last1_q;
        last1_d = color_i;
        cnt_d   = (cnt_q == HIST_FULL) ? cnt_q : cnt_q + CNT_W'(1);
        check_d = 1'b0;
      end else begin
        check_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last1_q <= '0;
      last2_q <= '0;
      cnt_q   <= '0;
      check_q <= 1'b0;
    end else begin
      last1_q <= last1_d;
      last2_q <= last2_d;
      cnt_q   <= cnt_d;
      check_q <= check_d;
    end
  end

  assign last1_o = last1_q;
  assign last2_o = last2_q;
  assign cnt_o   = cnt_q;
  assign check_o = check_q;

endmodule

// File: rtl/coloring_arbiter.sv
// Round-robin sharing of one coloring-rule checker among N_REQ color streams.
module coloring_arbiter
  import coloring_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  coloring_arbiter_if.slave bus
);

  color_t           col   [N_REQ];
  color_t           h_l1  [N_REQ];
  color_t           h_l2  [N_REQ];
  cnt_t             h_cnt [N_REQ];
  logic [N_REQ-1:0] h_chk;

  logic             gnt_any_c;
  logic [IDW-1:0]   gnt_id_c;
  logic [N_REQ-1:0] gnt_c;
  logic             rej_c;

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic             resp_ok_q, resp_ok_d;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign col[i] = bus.req_color[2*i +: 2];

    coloring_hist u_hist (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (bus.clr[i]),
      .upd_i   (gnt_c[i]),
      .ok_i    (!rej_c),
      .color_i (col[i]),
      .last1_o (h_l1[i]),
      .last2_o (h_l2[i]),
      .cnt_o   (h_cnt[i]),
      .check_o (h_chk[i])
    );
  end

  // Scan upward from ptr with wrap; a requester under clear is skipped.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    gnt_any_c = 1'b0;
    gnt_id_c  = '0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N_REQ)) sum = sum - (IDW+1)'(N_REQ);
      idx = IDW'(sum);
      if (!gnt_any_c && bus.req_valid[idx] && !bus.clr[idx]) begin
        gnt_any_c = 1'b1;
        gnt_id_c  = idx;
      end
    end
    if (!rst_n) gnt_any_c = 1'b0;
  end

  assign gnt_c = gnt_any_c ? (N_REQ'(1) << gnt_id_c) : '0;
  assign rej_c = color_reject(h_l1[gnt_id_c], h_l2[gnt_id_c], h_cnt[gnt_id_c], col[gnt_id_c]);

  always_comb begin
    ptr_d        = ptr_q;
    resp_valid_d = gnt_any_c;
    resp_id_d    = resp_id_q;
    resp_ok_d    = resp_ok_q;
    if (gnt_any_c) begin
      ptr_d     = (gnt_id_c == IDW'(N_REQ-1)) ? '0 : gnt_id_c + IDW'(1);
      resp_id_d = gnt_id_c;
      resp_ok_d = !rej_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_ok_q    <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_ok_q    <= resp_ok_d;
    end
  end

  assign bus.req_ready  = gnt_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_ok    = resp_ok_q;
  assign bus.check      = h_chk;

endmodule

// File: tb/tb_coloring_arbiter.sv
// Directed bench for coloring_arbiter with a per-cycle reference model.
module tb_coloring_arbiter;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  coloring_arbiter_if #(.N_REQ(N)) bus ();

  coloring_arbiter #(.N_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history per stream as plain integers.
  int m_l1  [N];
  int m_l2  [N];
  int m_cnt [N];
  bit m_chk [N];
  int m_ptr;
  bit m_rv;
  int m_id;
  bit m_ok;

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (bus.req_valid[i] && !bus.clr[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit model_reject(input int i, input int c);
    bit r1;
    bit r2;
    r1 = (m_cnt[i] == 2) && (m_l1[i] == c) && (m_l2[i] == c);
    r2 = (m_cnt[i] >= 1) && (m_l1[i] < 2) && (c < 2) && (m_l1[i] != c);
    return r1 || r2;
  endfunction

  initial begin
    m_ptr = 0; m_rv = 0; m_id = 0; m_ok = 0;
    for (int i = 0; i < N; i++) begin
      m_l1[i] = 0; m_l2[i] = 0; m_cnt[i] = 0; m_chk[i] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < N; i++) begin
          m_l1[i] = 0; m_l2[i] = 0; m_cnt[i] = 0; m_chk[i] = 0;
        end
        m_ptr = 0; m_rv = 0; m_id = 0; m_ok = 0;
      end else begin
        int g;
        int c;
        bit rej;
        g = model_grant();
        for (int i = 0; i < N; i++) begin
          if (bus.clr[i]) begin
            m_l1[i] = 0; m_l2[i] = 0; m_cnt[i] = 0; m_chk[i] = 0;
          end
        end
        if (g >= 0) begin
          c   = int'(bus.req_color[2*g +: 2]);
          rej = model_reject(g, c);
          if (rej) begin
            m_chk[g] = 1;
          end else begin
            m_l2[g] = m_l1[g];
            m_l1[g] = c;
            if (m_cnt[g] < 2) m_cnt[g] = m_cnt[g] + 1;
            m_chk[g] = 0;
          end
          m_rv  = 1;
          m_id  = g;
          m_ok  = !rej;
          m_ptr = (g + 1) % N;
        end else begin
          m_rv = 0;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      begin
        int g;
        logic [N-1:0] er;
        logic [N-1:0] ec;
        er = '0;
        if (rst_n) begin
          g = model_grant();
          if (g >= 0) er[g] = 1'b1;
        end
        for (int i = 0; i < N; i++) ec[i] = m_chk[i];
        chk("model_req_ready", bus.req_ready, er);
        chk("model_resp_valid", bus.resp_valid, m_rv);
        chk("model_resp_id", bus.resp_id, m_id);
        chk("model_resp_ok", bus.resp_ok, m_ok);
        chk("model_check", bus.check, ec);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic drive(input logic [N-1:0] v, input logic [2*N-1:0] col, input logic [N-1:0] c);
    bus.req_valid = v;
    bus.req_color = col;
    bus.clr       = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one color from a single requester; verdict is visible on return.
  task automatic send(input int i, input int c);
    logic [2*N-1:0] col;
    logic [N-1:0]   v;
    col = '0;
    col[2*i +: 2] = 2'(c);
    v = N'(1) << i;
    drive(v, col, '0);
    step();
    drive('0, col, '0);
  endtask

  initial begin
    int cols1 [5];
    int oks1  [5];
    int order [8];
    errors = 0;
    checks = 0;
    rst_n  = 1'b1;
    drive('0, '0, '0);
    #1 rst_n = 1'b0;
    bus.req_valid = '1;
    repeat (2) step();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_id", bus.resp_id, 0);
    chk("rst_resp_ok", bus.resp_ok, 0);
    chk("rst_check", bus.check, 0);
    bus.req_valid = '0;
    rst_n = 1'b1;

    // Requester 0: 0 ok, 1 rejected (0/1 adjacent), 2 ok.
    send(0, 0);
    chk("r0_c0_ok", bus.resp_ok, 1);
    chk("r0_c0_id", bus.resp_id, 0);
    chk("r0_c0_valid", bus.resp_valid, 1);
    send(0, 1);
    chk("r0_c1_ok", bus.resp_ok, 0);
    chk("r0_c1_check", bus.check[0], 1);
    send(0, 2);
    chk("r0_c2_ok", bus.resp_ok, 1);
    chk("r0_c2_check", bus.check[0], 0);

    // Requester 1: 3,3,3,2,3 -> third 3 rejected, then 3 after 2 is fine.
    cols1 = '{3, 3, 3, 2, 3};
    oks1  = '{1, 1, 0, 1, 1};
    for (int k = 0; k < 5; k++) begin
      send(1, cols1[k]);
      chk("r1_seq_ok", bus.resp_ok, oks1[k]);
      chk("r1_seq_id", bus.resp_id, 1);
    end

    // All requesters valid; pointer sits at 2 after the last grant to 1.
    order = '{2, 3, 0, 1, 2, 3, 0, 1};
    drive('1, {2'd2, 2'd3, 2'd2, 2'd3}, '0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_resp_id", bus.resp_id, order[k]);
      chk("rr_resp_valid", bus.resp_valid, 1);
    end
    drive('0, '0, '0);
    step();
    chk("rr_idle_valid", bus.resp_valid, 0);

    // Requester 2: clear, then history 0, then clr masks a pending color 1.
    drive('0, '0, 4'b0100);
    step();
    chk("r2_clr_check", bus.check[2], 0);
    send(2, 0);
    chk("r2_c0_ok", bus.resp_ok, 1);
    drive(4'b0100, 8'b0001_0000, 4'b0100);
    #1;
    chk("r2_clr_ready", bus.req_ready, 0);
    step();
    chk("r2_clr_no_resp", bus.resp_valid, 0);
    drive(4'b0100, 8'b0001_0000, 4'b0000);
    #1;
    chk("r2_post_clr_ready", bus.req_ready, 4'b0100);
    step();
    drive('0, '0, '0);
    chk("r2_post_clr_ok", bus.resp_ok, 1);
    chk("r2_post_clr_id", bus.resp_id, 2);
    chk("r2_post_clr_check", bus.check[2], 0);

    // Requester 3: 3,3,3 then mid-cycle reset wipes history.
    send(3, 3);
    send(3, 3);
    chk("r3_c33_ok", bus.resp_ok, 1);
    send(3, 3);
    chk("r3_c333_ok", bus.resp_ok, 0);
    chk("r3_c333_check", bus.check, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.resp_valid, 0);
    chk("mid_rst_id", bus.resp_id, 0);
    chk("mid_rst_ok", bus.resp_ok, 0);
    chk("mid_rst_check", bus.check, 0);
    bus.req_valid = 4'b1000;
    #1;
    chk("mid_rst_ready", bus.req_ready, 0);
    bus.req_valid = '0;
    #4 rst_n = 1'b1;
    send(3, 3);
    chk("r3_after_rst_ok", bus.resp_ok, 1);
    chk("r3_after_rst_id", bus.resp_id, 3);

    // Independent histories: r0 sends 0 and r1 sends 1 together.
    drive(4'b0011, 8'b0000_0100, '0);
    step();
    chk("ilv_first_id", bus.resp_id, 0);
    chk("ilv_first_ok", bus.resp_ok, 1);
    drive(4'b0010, 8'b0000_0100, '0);
    step();
    chk("ilv_second_id", bus.resp_id, 1);
    chk("ilv_second_ok", bus.resp_ok, 1);
    drive('0, '0, '0);
    step();
    chk("ilv_idle_valid", bus.resp_valid, 0);
    chk("ilv_idle_id_hold", bus.resp_id, 1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
